// File: rtl/conv_1d_pkg.sv
// Shared types and width helpers for the 1-D BRAM convolution controller.
package conv_1d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_WAIT_LAST = 3'd3,
        ST_DONE      = 3'd4
    } ctrl_state_t;

    // Address width that never collapses to zero bits for single-entry memories.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int result_w(input int img_w, input int filter_l, input int stride_w);
        return (img_w - filter_l) / stride_w + 1;
    endfunction

endpackage

// File: rtl/conv_ctrl_delay.sv
// LAT-stage 1-bit pipeline aligning the read enable with BRAM read data.
module conv_ctrl_delay #(
    parameter int LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [LAT-1:0] r_sr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < LAT; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[LAT-1];

endmodule

// File: rtl/conv_bram_1d_ctrl.sv
// Control FSM for a 1-D sliding-window convolution over an image BRAM row:
// streams the row out, marks qualifying windows and waits for the datapath's final write.
module conv_bram_1d_ctrl
    import conv_1d_pkg::*;
#(
    parameter int IMG_W      = 32,
    parameter int FILTER_L   = 3,
    parameter int STRIDE_W   = 1,
    parameter int RAM_RD_LAT = 1,
    localparam int RESULT_W              = result_w(IMG_W, FILTER_L, STRIDE_W),
    localparam int IMG_RAM_ADDR_WIDTH    = addr_w(IMG_W),
    localparam int RESULT_RAM_ADDR_WIDTH = addr_w(RESULT_W)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
    output logic                             img_rden,
    output logic                             dpath_sr_wren,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
    output logic                             dpath_result_wren,
    input  logic                             last_val
);

    localparam int IAW = IMG_RAM_ADDR_WIDTH;
    localparam int RAW = RESULT_RAM_ADDR_WIDTH;
    localparam int PW  = addr_w(STRIDE_W);

    localparam logic [IAW-1:0] C_IMG_LAST   = IAW'(IMG_W - 1);
    localparam logic [IAW-1:0] C_FIRST_COL  = IAW'(FILTER_L - 1);
    localparam logic [RAW-1:0] C_RES_LAST   = RAW'(RESULT_W - 1);
    localparam logic [PW-1:0]  C_PHASE_LAST = PW'(STRIDE_W - 1);

    ctrl_state_t    r_state;
    logic [IAW-1:0] r_rdaddr;
    logic           r_rden;
    logic [IAW-1:0] r_col;
    logic [PW-1:0]  r_phase;
    logic [RAW-1:0] r_wraddr;
    logic           r_wren;
    logic           r_last_seen;
    logic           r_wr_done;

    logic           w_sr_wren;
    logic [PW-1:0]  w_phase;
    logic           w_qualify;
    logic           w_last_wr;

    conv_ctrl_delay #(.LAT(RAM_RD_LAT)) u_rd_delay (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (r_rden),
        .o_q     (w_sr_wren)
    );

    // r_col is the column currently shifting in; the stride phase restarts at the first full window.
    assign w_phase   = (r_col == C_FIRST_COL) ? '0 : r_phase;
    assign w_qualify = w_sr_wren && (r_col >= C_FIRST_COL) && (w_phase == '0);
    assign w_last_wr = r_wren && (r_wraddr == C_RES_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col    <= '0;
            r_phase  <= '0;
            r_wraddr <= '0;
            r_wren   <= 1'b0;
        end else begin
            r_wren <= w_qualify;
            if (w_qualify) begin
                r_wraddr <= (r_col == C_FIRST_COL) ? '0 : r_wraddr + RAW'(1);
            end
            if (r_state == ST_IDLE && start) begin
                r_col   <= '0;
                r_phase <= '0;
            end else if (w_sr_wren) begin
                r_col <= r_col + IAW'(1);
                if (r_col >= C_FIRST_COL) begin
                    r_phase <= (w_phase == C_PHASE_LAST) ? '0 : w_phase + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rdaddr    <= '0;
            r_rden      <= 1'b0;
            r_last_seen <= 1'b0;
            r_wr_done   <= 1'b0;
        end else begin
            if (r_state != ST_IDLE && last_val) r_last_seen <= 1'b1;
            if (w_last_wr) r_wr_done <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_READ;
                        r_rden      <= 1'b1;
                        r_rdaddr    <= '0;
                        r_last_seen <= 1'b0;
                        r_wr_done   <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (r_rdaddr == C_IMG_LAST) begin
                        r_rden  <= 1'b0;
                        r_state <= ST_FLUSH;
                    end else begin
                        r_rdaddr <= r_rdaddr + IAW'(1);
                    end
                end
                // A very short result row can finish writing while still reading.
                ST_FLUSH:     if (w_last_wr || r_wr_done) r_state <= ST_WAIT_LAST;
                ST_WAIT_LAST: if (r_last_seen || last_val) r_state <= ST_DONE;
                ST_DONE:      r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy                = (r_state != ST_IDLE);
    assign done                = (r_state == ST_DONE);
    assign img_rdaddr          = r_rdaddr;
    assign img_rden            = r_rden;
    assign dpath_sr_wren       = w_sr_wren;
    assign dpath_result_wraddr = r_wraddr;
    assign dpath_result_wren   = r_wren;

endmodule

// File: tb/tb_conv_bram_1d_ctrl.sv
// Directed bench for conv_bram_1d_ctrl: three parameterisations behind one
// observation mux, write-side scoreboard of {cycle offset, result index}.
module tb_conv_bram_1d_ctrl;

  logic clk;
  logic reset;
  logic start;
  logic last_val;
  logic [1:0] sel;
  int cyc;
  int t0;
  bit mon_en;
  int n_assert;
  int n_fail;
  logic [23:0] exp_q[$];

  // instance a: defaults; b: IMG_W=8 STRIDE_W=2; c: RAM_RD_LAT=2
  logic a_busy, a_done, a_rden, a_sr, a_wren;
  logic [4:0] a_rdaddr, a_wraddr;
  logic b_busy, b_done, b_rden, b_sr, b_wren;
  logic [2:0] b_rdaddr;
  logic [1:0] b_wraddr;
  logic c_busy, c_done, c_rden, c_sr, c_wren;
  logic [4:0] c_rdaddr, c_wraddr;

  logic obs_busy, obs_done, obs_rden, obs_sr, obs_wren;
  logic [7:0] obs_rdaddr, obs_wraddr;

  conv_bram_1d_ctrl u_a (
    .clk(clk), .reset(reset), .start(start && sel == 2'd0), .busy(a_busy), .done(a_done),
    .img_rdaddr(a_rdaddr), .img_rden(a_rden), .dpath_sr_wren(a_sr),
    .dpath_result_wraddr(a_wraddr), .dpath_result_wren(a_wren),
    .last_val(last_val && sel == 2'd0)
  );

  conv_bram_1d_ctrl #(.IMG_W(8), .FILTER_L(3), .STRIDE_W(2), .RAM_RD_LAT(1)) u_b (
    .clk(clk), .reset(reset), .start(start && sel == 2'd1), .busy(b_busy), .done(b_done),
    .img_rdaddr(b_rdaddr), .img_rden(b_rden), .dpath_sr_wren(b_sr),
    .dpath_result_wraddr(b_wraddr), .dpath_result_wren(b_wren),
    .last_val(last_val && sel == 2'd1)
  );

  conv_bram_1d_ctrl #(.RAM_RD_LAT(2)) u_c (
    .clk(clk), .reset(reset), .start(start && sel == 2'd2), .busy(c_busy), .done(c_done),
    .img_rdaddr(c_rdaddr), .img_rden(c_rden), .dpath_sr_wren(c_sr),
    .dpath_result_wraddr(c_wraddr), .dpath_result_wren(c_wren),
    .last_val(last_val && sel == 2'd2)
  );

  always_comb begin
    obs_busy = a_busy; obs_done = a_done; obs_rden = a_rden; obs_sr = a_sr; obs_wren = a_wren;
    obs_rdaddr = 8'(a_rdaddr); obs_wraddr = 8'(a_wraddr);
    if (sel == 2'd1) begin
      obs_busy = b_busy; obs_done = b_done; obs_rden = b_rden; obs_sr = b_sr; obs_wren = b_wren;
      obs_rdaddr = 8'(b_rdaddr); obs_wraddr = 8'(b_wraddr);
    end else if (sel == 2'd2) begin
      obs_busy = c_busy; obs_done = c_done; obs_rden = c_rden; obs_sr = c_sr; obs_wren = c_wren;
      obs_rdaddr = 8'(c_rdaddr); obs_wraddr = 8'(c_wraddr);
    end
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: each result write must match the next expected {offset, index}
  always @(negedge clk) begin
    if (mon_en && reset && obs_wren) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL wr_unexpected: observed write idx %0d at offset %0d expected none", obs_wraddr, cyc - t0);
      end else begin
        check("wr", {8'h0, 16'(cyc - t0), obs_wraddr}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, obs_busy, 0);
    check({tag, "_done"}, obs_done, 0);
    check({tag, "_rden"}, obs_rden, 0);
    check({tag, "_rdaddr"}, obs_rdaddr, 0);
    check({tag, "_sr"}, obs_sr, 0);
    check({tag, "_wren"}, obs_wren, 0);
    check({tag, "_wraddr"}, obs_wraddr, 0);
  endtask

  // One pass on instance s. lv_rel places last_val relative to the last write;
  // hold keeps start high until the done cycle; abort_off>0 pulls reset at that offset.
  task automatic run_pass(input int s, input int w, input int f, input int st, input int l,
                          input int lv_rel, input bit hold, input int abort_off);
    int n;
    int last_wr_off;
    int lv_off;
    int done_off;
    n = 0;
    last_wr_off = 0;
    sel = 2'(s);
    exp_q.delete();
    for (int c = 0; c < w; c++) begin
      if (c >= f - 1 && ((c - (f - 1)) % st) == 0) begin
        exp_q.push_back({16'(2 + l + c), 8'(n)});
        n++;
        last_wr_off = 2 + l + c;
      end
    end
    lv_off = last_wr_off + lv_rel;
    done_off = (lv_off + 1 > last_wr_off + 2) ? lv_off + 1 : last_wr_off + 2;
    @(negedge clk);
    t0 = cyc;
    mon_en = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= done_off + 2; k++) begin
      @(negedge clk);
      check("rden", obs_rden, (k <= w) ? 1 : 0);
      if (k <= w) check("rdaddr", obs_rdaddr, k - 1);
      check("sr_wren", obs_sr, (k >= 1 + l && k <= w + l) ? 1 : 0);
      check("busy", obs_busy, (k <= done_off) ? 1 : 0);
      check("done", obs_done, (k == done_off) ? 1 : 0);
      if (k == abort_off) begin
        reset = 1'b0;
        start = 1'b0;
        last_val = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        mon_en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("abort_done", obs_done, 0);
          check("abort_busy", obs_busy, 0);
        end
        reset = 1'b1;
        return;
      end
      start = hold && (k < done_off);
      last_val = (k == lv_off);
    end
    last_val = 1'b0;
    check("wr_left", exp_q.size(), 0);
    check("rdaddr_hold", obs_rdaddr, w - 1);
    check("wraddr_hold", obs_wraddr, n - 1);
    mon_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    last_val = 1'b0;
    sel = 2'd0;
    mon_en = 1'b0;
    t0 = 0;
    n_assert = 0;
    n_fail = 0;
    #2 reset = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check_all_zero("reset");
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_pass(0, 32, 3, 1, 1, 4, 1'b0, 0);
    run_pass(1, 8, 3, 2, 1, 2, 1'b0, 0);
    run_pass(2, 32, 3, 1, 2, 1, 1'b0, 0);
    run_pass(0, 32, 3, 1, 1, 4, 1'b1, 0);
    run_pass(0, 32, 3, 1, 1, 4, 1'b0, 10);
    run_pass(0, 32, 3, 1, 1, 4, 1'b0, 0);
    run_pass(0, 32, 3, 1, 1, -1, 1'b0, 0);
    run_pass(2, 32, 3, 1, 2, -20, 1'b0, 0);
    run_pass(2, 32, 3, 1, 2, 3, 1'b0, 0);
    run_pass(1, 8, 3, 2, 1, 0, 1'b1, 0);
    run_pass(1, 8, 3, 2, 1, 5, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
